match_monitor: RTL

- Sits directly downstream of the dual-register equality comparator and consumes its complementary match/mismatch flags.
- Samples the flag pair on a strobe and qualifies the comparison stream over time.
- Declares LOCK after LOCK_N consecutive matches and ALARM after FAIL_N consecutive mismatches.
- Keeps saturating totals of matches and mismatches for status readout.

---
 rtl/match_monitor_if.sv | 28 ++
 rtl/match_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/match_monitor_if.sv
// Comparator-flag input bundle and qualification status outputs for match_monitor.
// The master drives strobe/flags/controls; the slave (the monitor) returns status.
interface match_monitor_if #(
  parameter int C = 8
);
  logic         enable;
  logic         sample;
  logic         match_in;
  logic         mismatch_in;
  logic         clear;
  logic [1:0]   state;
  logic         locked;
  logic         alarm;
  logic         protocol_err;
  logic [C-1:0] run_len;
  logic [C-1:0] match_cnt;
  logic [C-1:0] miss_cnt;

  modport master (
    output enable, sample, match_in, mismatch_in, clear,
    input  state, locked, alarm, protocol_err, run_len, match_cnt, miss_cnt
  );

  modport slave (
    input  enable, sample, match_in, mismatch_in, clear,
    output state, locked, alarm, protocol_err, run_len, match_cnt, miss_cnt
  );
endinterface

// File: rtl/match_monitor.sv
// Qualifies a strobed match/mismatch flag stream into SEEK/LOCKED/ALARM with saturating totals.
// Latency: 1 cycle from sample to every output; no backpressure, every strobe is consumed or ignored.
module match_monitor #(
  parameter int C      = 8,
  parameter int LOCK_N = 4,
  parameter int FAIL_N = 3
) (
  input  logic           clk,
  input  logic           reset,
  match_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEEK   = 2'b01,
    LOCKED = 2'b10,
    ALARM  = 2'b11
  } state_e;

  localparam logic [C:0] LOCK_W = (C+1)'(LOCK_N);
  localparam logic [C:0] FAIL_W = (C+1)'(FAIL_N);

  state_e       state_q, state_d;
  logic [C-1:0] run_len_q, run_len_d;
  logic [C-1:0] miss_run_q, miss_run_d;
  logic [C-1:0] match_cnt_q, match_cnt_d;
  logic [C-1:0] miss_cnt_q, miss_cnt_d;
  logic         perr_q, perr_d;
  logic         locked_q, locked_d;
  logic         alarm_q, alarm_d;

  // One extra bit so the threshold test still works once a run has saturated.
  logic [C:0]   run_inc;
  logic [C:0]   miss_run_inc;
  logic [C:0]   match_cnt_inc;
  logic [C:0]   miss_cnt_inc;
  logic         flags_ok;

  always_comb begin
    state_d       = state_q;
    run_len_d     = run_len_q;
    miss_run_d    = miss_run_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    perr_d        = perr_q;
    run_inc       = {1'b0, run_len_q}   + (C+1)'(1);
    miss_run_inc  = {1'b0, miss_run_q}  + (C+1)'(1);
    match_cnt_inc = {1'b0, match_cnt_q} + (C+1)'(1);
    miss_cnt_inc  = {1'b0, miss_cnt_q}  + (C+1)'(1);
    flags_ok      = (mon.match_in != mon.mismatch_in);

    if (mon.clear) begin
      state_d     = IDLE;
      run_len_d   = '0;
      miss_run_d  = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      perr_d      = 1'b0;
    end else if (state_q == ALARM) begin
      state_d = ALARM;
    end else if (!mon.enable) begin
      state_d    = IDLE;
      run_len_d  = '0;
      miss_run_d = '0;
    end else if (state_q == IDLE) begin
      state_d    = SEEK;
      run_len_d  = '0;
      miss_run_d = '0;
    end else if (mon.sample) begin
      if (!flags_ok) begin
        perr_d = 1'b1;
      end else if (mon.match_in) begin
        match_cnt_d = match_cnt_inc[C] ? match_cnt_q : match_cnt_inc[C-1:0];
        run_len_d   = run_inc[C] ? run_len_q : run_inc[C-1:0];
        miss_run_d  = '0;
        if (run_inc >= LOCK_W) begin
          state_d = LOCKED;
        end
      end else begin
        miss_cnt_d = miss_cnt_inc[C] ? miss_cnt_q : miss_cnt_inc[C-1:0];
        run_len_d  = '0;
        miss_run_d = miss_run_inc[C] ? miss_run_q : miss_run_inc[C-1:0];
        if (miss_run_inc >= FAIL_W) begin
          state_d = ALARM;
        end
      end
    end

    locked_d = (state_d == LOCKED);
    alarm_d  = (state_d == ALARM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      run_len_q   <= '0;
      miss_run_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      perr_q      <= 1'b0;
      locked_q    <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      miss_run_q  <= miss_run_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      perr_q      <= perr_d;
      locked_q    <= locked_d;
      alarm_q     <= alarm_d;
    end
  end

  assign mon.state        = state_q;
  assign mon.locked       = locked_q;
  assign mon.alarm        = alarm_q;
  assign mon.protocol_err = perr_q;
  assign mon.run_len      = run_len_q;
  assign mon.match_cnt    = match_cnt_q;
  assign mon.miss_cnt     = miss_cnt_q;

endmodule
